// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the MEM-stage wait-state responder.
// Holds the FSM state enum, the read-data source select and defaults.
package mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    RD_ZERO,
    RD_ARRAY,
    RD_POISON
  } rd_src_t;

  localparam logic [31:0] POISON_DATA = 32'hDEAD_BEEF;
  localparam int DEF_BASE_ADDR = 1024;
  localparam int DEF_DEPTH = 2048;

endpackage

// File: rtl/mem_resp_array.sv
// Single-port word array: synchronous write, registered read, no reset.
// Ports: clk, we, re, idx, wdata, rdata (rdata holds until next re).
module mem_resp_array #(
  parameter int DEPTH = 2048,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
    if (re) rdata <= mem[idx];
  end

endmodule

// File: rtl/mem_wait_responder.sv
// MEM-stage memory responder with programmable wait states.
// Ports: clk, rst (async, active-low), read_en, write_en, address,
// writeData -> readData, ready; err when MEM_RESP_RANGE_CHECK_EN is set.
module mem_wait_responder
  import mem_resp_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WAIT_CYCLES = 5,
  parameter int BASE_ADDR = DEF_BASE_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read_en,
  input  logic        write_en,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        ready
`ifdef MEM_RESP_RANGE_CHECK_EN
  ,
  output logic        err
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW =
    (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_INIT =
    CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  localparam bit ZERO_WAIT = (WAIT_CYCLES == 0);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  rd_src_t       src_q, src_d;
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic          wr_q;
  logic          oor_q;

  logic          req;
  logic [31:0]   offset;
  logic [AW-1:0] idx_in;
  logic          oor_in;
  logic          accept;
  logic          go;
  logic          live;
  logic          acc_wr;
  logic          acc_oor;
  logic [AW-1:0] acc_idx;
  logic [31:0]   acc_wdata;
  logic          arr_we;
  logic          arr_re;
  logic [31:0]   arr_rdata;

  assign req    = read_en | write_en;
  assign offset = address - 32'(BASE_ADDR);
  assign idx_in = AW'(offset >> 2);
  assign accept = (state_q == IDLE) && req;

`ifdef MEM_RESP_RANGE_CHECK_EN
  localparam logic [32:0] LO_ADDR = 33'(BASE_ADDR);
  localparam logic [32:0] HI_ADDR =
    33'(BASE_ADDR) + 33'(4 * DEPTH);

  assign oor_in = ({1'b0, address} < LO_ADDR) ||
                  ({1'b0, address} >= HI_ADDR);
  assign err = (state_q == DONE) && oor_q;
`else
  assign oor_in = 1'b0;
`endif

  // Zero wait states: the access happens on the accept edge,
  // so it must use the live request instead of the latches.
  assign live = (state_q == IDLE);
  assign go   = ((state_q == WAIT) && (cnt_q == '0)) ||
                (accept && ZERO_WAIT);

  assign acc_wr    = live ? write_en  : wr_q;
  assign acc_oor   = live ? oor_in    : oor_q;
  assign acc_idx   = live ? idx_in    : idx_q;
  assign acc_wdata = live ? writeData : wdata_q;

  assign arr_we = go && acc_wr && !acc_oor;
  assign arr_re = go && !acc_wr && !acc_oor;

  mem_resp_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .re    (arr_re),
    .idx   (acc_idx),
    .wdata (acc_wdata),
    .rdata (arr_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready   = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready = ~req;
        if (req) begin
          state_d = ZERO_WAIT ? DONE : WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        ready   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // readData source: the array's registered output is not
  // resettable, so reset and poison are muxed in front of it.
  always_comb begin
    src_d = src_q;
    if (go && !acc_wr) begin
      src_d = acc_oor ? RD_POISON : RD_ARRAY;
    end
  end

  always_comb begin
    readData = '0;
    unique case (src_q)
      RD_ARRAY:  readData = arr_rdata;
      RD_POISON: readData = POISON_DATA;
      default:   readData = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      src_q   <= RD_ZERO;
      idx_q   <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      oor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      if (accept) begin
        idx_q   <= idx_in;
        wdata_q <= writeData;
        wr_q    <= write_en;
        oor_q   <= oor_in;
      end
    end
  end

endmodule
